// File: rtl/chromite_probe_pkg.sv
// Shared widths and the registered probe record for the chromite pipeline probe.
package chromite_probe_pkg;

    localparam int XLEN    = 64;
    localparam int DEC_W   = 75;
    localparam int REDIR_W = 65;
    localparam int PRED_W  = 67;
    localparam int CNT_W   = 32;

    // Field order follows the p_ output ports.
    typedef struct packed {
        logic               rg_eEpoch;
        logic               rg_wEpoch;
        logic               rg_fence;
        logic               rg_sfence;
        logic [XLEN-1:0]    rg_pc_D_IN;
        logic [XLEN-1:0]    rg_pc;
        logic               rg_pc_EN;
        logic [REDIR_W-1:0] rg_delayed_redirect;
        logic               ma_flush_fl;
        logic [PRED_W-1:0]  bpu_pred;
        logic [DEC_W-1:0]   decoder_func_32;
        logic               EN_update_eEpoch;
        logic               EN_update_wEpoch;
    } probe_rec_t;

endpackage

// File: rtl/chromite_pipe_probe_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, clamps at all-ones, synchronous clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg = '0;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum        = {1'b0, count_reg} + {{(CNT_W-1){1'b0}}, inc};
        // A carry out of the top bit means we passed the maximum: clamp.
        count_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        if (clr) begin
            count_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/chromite_pipe_probe.sv
// Passive pipeline probe: registers stage0/stage2 signals one cycle late and counts events.
module chromite_pipe_probe
    import chromite_probe_pkg::*;
#(
    parameter int CNT_W = chromite_probe_pkg::CNT_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               s0_rg_eEpoch,
    input  logic               s0_rg_wEpoch,
    input  logic               s0_rg_fence,
    input  logic               s0_rg_sfence,
    input  logic [XLEN-1:0]    s0_rg_pc_D_IN,
    input  logic [XLEN-1:0]    s0_rg_pc,
    input  logic               s0_rg_pc_EN,
    input  logic [REDIR_W-1:0] s0_rg_delayed_redirect,
    input  logic               s0_ma_flush_fl,
    input  logic [PRED_W-1:0]  s0_bpu_pred,
    input  logic [DEC_W-1:0]   s2_decoder_func_32,
    input  logic               s2_EN_update_eEpoch,
    input  logic               s2_EN_update_wEpoch,
    output logic               p_rg_eEpoch,
    output logic               p_rg_wEpoch,
    output logic               p_rg_fence,
    output logic               p_rg_sfence,
    output logic [XLEN-1:0]    p_rg_pc_D_IN,
    output logic [XLEN-1:0]    p_rg_pc,
    output logic               p_rg_pc_EN,
    output logic [REDIR_W-1:0] p_rg_delayed_redirect,
    output logic               p_ma_flush_fl,
    output logic [PRED_W-1:0]  p_bpu_pred,
    output logic [DEC_W-1:0]   p_decoder_func_32,
    output logic               p_EN_update_eEpoch,
    output logic               p_EN_update_wEpoch,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   pc_write_cnt,
    output logic [CNT_W-1:0]   epoch_upd_cnt
);

    probe_rec_t probe_reg = '0;
    probe_rec_t probe_next;
    logic       cnt_clr;
    logic [1:0] flush_inc;
    logic [1:0] pc_write_inc;
    logic [1:0] epoch_inc;

    // Stage0 fields keep sampling through reset so the fetch state stays visible.
    always_comb begin
        probe_next.rg_eEpoch           = s0_rg_eEpoch;
        probe_next.rg_wEpoch           = s0_rg_wEpoch;
        probe_next.rg_fence            = s0_rg_fence;
        probe_next.rg_sfence           = s0_rg_sfence;
        probe_next.rg_pc_D_IN          = s0_rg_pc_D_IN;
        probe_next.rg_pc               = s0_rg_pc;
        probe_next.rg_pc_EN            = s0_rg_pc_EN;
        probe_next.rg_delayed_redirect = s0_rg_delayed_redirect;
        probe_next.ma_flush_fl         = s0_ma_flush_fl;
        probe_next.bpu_pred            = s0_bpu_pred;
        probe_next.decoder_func_32     = RST_N ? s2_decoder_func_32  : '0;
        probe_next.EN_update_eEpoch    = RST_N ? s2_EN_update_eEpoch : 1'b0;
        probe_next.EN_update_wEpoch    = RST_N ? s2_EN_update_wEpoch : 1'b0;
    end

    always_ff @(posedge CLK) begin
        probe_reg <= probe_next;
    end

    assign p_rg_eEpoch           = probe_reg.rg_eEpoch;
    assign p_rg_wEpoch           = probe_reg.rg_wEpoch;
    assign p_rg_fence            = probe_reg.rg_fence;
    assign p_rg_sfence           = probe_reg.rg_sfence;
    assign p_rg_pc_D_IN          = probe_reg.rg_pc_D_IN;
    assign p_rg_pc               = probe_reg.rg_pc;
    assign p_rg_pc_EN            = probe_reg.rg_pc_EN;
    assign p_rg_delayed_redirect = probe_reg.rg_delayed_redirect;
    assign p_ma_flush_fl         = probe_reg.ma_flush_fl;
    assign p_bpu_pred            = probe_reg.bpu_pred;
    assign p_decoder_func_32     = probe_reg.decoder_func_32;
    assign p_EN_update_eEpoch    = probe_reg.EN_update_eEpoch;
    assign p_EN_update_wEpoch    = probe_reg.EN_update_wEpoch;

    assign cnt_clr      = ~RST_N;
    assign flush_inc    = {1'b0, s0_ma_flush_fl};
    assign pc_write_inc = {1'b0, s0_rg_pc_EN};
    assign epoch_inc    = {1'b0, s2_EN_update_eEpoch} + {1'b0, s2_EN_update_wEpoch};

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clr   (cnt_clr),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pc_write_cnt (
        .CLK   (CLK),
        .clr   (cnt_clr),
        .inc   (pc_write_inc),
        .count (pc_write_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_epoch_upd_cnt (
        .CLK   (CLK),
        .clr   (cnt_clr),
        .inc   (epoch_inc),
        .count (epoch_upd_cnt)
    );

endmodule

// File: tb/tb_chromite_pipe_probe.sv
// Randomised and directed check of chromite_pipe_probe against a cycle-level reference model.
module tb_chromite_pipe_probe;
    import chromite_probe_pkg::*;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic       CLK = 1'b0;
    logic       RST_N;
    probe_rec_t stim;
    probe_rec_t obs_rec;
    probe_rec_t exp_rec;

    logic               p_rg_eEpoch, p_rg_wEpoch, p_rg_fence, p_rg_sfence;
    logic [XLEN-1:0]    p_rg_pc_D_IN, p_rg_pc;
    logic               p_rg_pc_EN, p_ma_flush_fl;
    logic [REDIR_W-1:0] p_rg_delayed_redirect;
    logic [PRED_W-1:0]  p_bpu_pred;
    logic [DEC_W-1:0]   p_decoder_func_32;
    logic               p_EN_update_eEpoch, p_EN_update_wEpoch;
    logic [CW-1:0]      flush_cnt, pc_write_cnt, epoch_upd_cnt;

    int exp_flush, exp_pc_write, exp_epoch;
    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    chromite_pipe_probe #(.CNT_W(CW)) dut (
        .CLK                    (CLK),
        .RST_N                  (RST_N),
        .s0_rg_eEpoch           (stim.rg_eEpoch),
        .s0_rg_wEpoch           (stim.rg_wEpoch),
        .s0_rg_fence            (stim.rg_fence),
        .s0_rg_sfence           (stim.rg_sfence),
        .s0_rg_pc_D_IN          (stim.rg_pc_D_IN),
        .s0_rg_pc               (stim.rg_pc),
        .s0_rg_pc_EN            (stim.rg_pc_EN),
        .s0_rg_delayed_redirect (stim.rg_delayed_redirect),
        .s0_ma_flush_fl         (stim.ma_flush_fl),
        .s0_bpu_pred            (stim.bpu_pred),
        .s2_decoder_func_32     (stim.decoder_func_32),
        .s2_EN_update_eEpoch    (stim.EN_update_eEpoch),
        .s2_EN_update_wEpoch    (stim.EN_update_wEpoch),
        .p_rg_eEpoch            (p_rg_eEpoch),
        .p_rg_wEpoch            (p_rg_wEpoch),
        .p_rg_fence             (p_rg_fence),
        .p_rg_sfence            (p_rg_sfence),
        .p_rg_pc_D_IN           (p_rg_pc_D_IN),
        .p_rg_pc                (p_rg_pc),
        .p_rg_pc_EN             (p_rg_pc_EN),
        .p_rg_delayed_redirect  (p_rg_delayed_redirect),
        .p_ma_flush_fl          (p_ma_flush_fl),
        .p_bpu_pred             (p_bpu_pred),
        .p_decoder_func_32      (p_decoder_func_32),
        .p_EN_update_eEpoch     (p_EN_update_eEpoch),
        .p_EN_update_wEpoch     (p_EN_update_wEpoch),
        .flush_cnt              (flush_cnt),
        .pc_write_cnt           (pc_write_cnt),
        .epoch_upd_cnt          (epoch_upd_cnt)
    );

    assign obs_rec = probe_rec_t'({p_rg_eEpoch, p_rg_wEpoch, p_rg_fence, p_rg_sfence,
                                   p_rg_pc_D_IN, p_rg_pc, p_rg_pc_EN, p_rg_delayed_redirect,
                                   p_ma_flush_fl, p_bpu_pred, p_decoder_func_32,
                                   p_EN_update_eEpoch, p_EN_update_wEpoch});

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int c, input int inc);
        return (c + inc > CNT_MAX) ? CNT_MAX : c + inc;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rec"},   512'(obs_rec),       512'(exp_rec));
        check({tag, ".flush"}, 512'(flush_cnt),     512'(exp_flush));
        check({tag, ".pcw"},   512'(pc_write_cnt),  512'(exp_pc_write));
        check({tag, ".epoch"}, 512'(epoch_upd_cnt), 512'(exp_epoch));
    endtask

    // One clock edge: the model consumes what the DUT sampled, then outputs are compared.
    task automatic step(input string tag);
        @(posedge CLK);
        exp_rec = stim;
        if (!RST_N) begin
            exp_rec.decoder_func_32  = '0;
            exp_rec.EN_update_eEpoch = 1'b0;
            exp_rec.EN_update_wEpoch = 1'b0;
            exp_flush    = 0;
            exp_pc_write = 0;
            exp_epoch    = 0;
        end else begin
            exp_flush    = sat_add(exp_flush, int'(stim.ma_flush_fl));
            exp_pc_write = sat_add(exp_pc_write, int'(stim.rg_pc_EN));
            exp_epoch    = sat_add(exp_epoch, int'(stim.EN_update_eEpoch) + int'(stim.EN_update_wEpoch));
        end
        #1;
        check_all(tag);
        $display("cycle %s rst_n=%0b pc=%0h flush=%0d pcw=%0d epoch=%0d",
                 tag, RST_N, p_rg_pc, flush_cnt, pc_write_cnt, epoch_upd_cnt);
    endtask

    task automatic randomize_stim();
        logic [351:0] bits;
        for (int i = 0; i < 11; i++) bits[i*32 +: 32] = $urandom;
        stim = probe_rec_t'(bits[$bits(probe_rec_t)-1:0]);
    endtask

    initial begin
        RST_N        = 1'b0;
        stim         = '0;
        exp_rec      = '0;
        exp_flush    = 0;
        exp_pc_write = 0;
        exp_epoch    = 0;

        // Power-up values, before the first edge
        #1;
        check_all("powerup");

        // Reset: stage0 visible, stage2 and counters cleared
        stim.rg_pc            = 64'h8000_0000;
        stim.decoder_func_32  = '1;
        stim.EN_update_eEpoch = 1'b1;
        step("reset");
        check("reset.pc",  512'(p_rg_pc), 512'(64'h8000_0000));
        check("reset.dec", 512'(p_decoder_func_32), 512'(0));

        // PC writes for three cycles
        RST_N = 1'b1;
        stim  = '0;
        stim.rg_pc_D_IN = 64'h8000_0004;
        stim.rg_pc_EN   = 1'b1;
        for (int i = 0; i < 3; i++) step("pcw");
        stim.rg_pc_EN = 1'b0;
        check("pcw.count", 512'(pc_write_cnt), 512'(3));
        check("pcw.din",   512'(p_rg_pc_D_IN), 512'(64'h8000_0004));

        // Single flush and a double epoch strobe
        stim.ma_flush_fl      = 1'b1;
        stim.EN_update_eEpoch = 1'b1;
        stim.EN_update_wEpoch = 1'b1;
        step("pulse");
        stim.ma_flush_fl      = 1'b0;
        stim.EN_update_eEpoch = 1'b0;
        stim.EN_update_wEpoch = 1'b0;
        step("idle");
        check("pulse.flush", 512'(flush_cnt), 512'(1));
        check("pulse.epoch", 512'(epoch_upd_cnt), 512'(2));

        // Walk epoch counter from 2 up to 14, then +2 and +1 must both stop at 15
        stim.EN_update_eEpoch = 1'b1;
        stim.EN_update_wEpoch = 1'b1;
        for (int i = 0; i < 6; i++) step("preload");
        check("sat.pre", 512'(epoch_upd_cnt), 512'(14));
        step("sat2");
        check("sat.plus2", 512'(epoch_upd_cnt), 512'(15));
        stim.EN_update_wEpoch = 1'b0;
        step("sat1");
        check("sat.plus1", 512'(epoch_upd_cnt), 512'(15));
        stim.EN_update_eEpoch = 1'b0;

        // Redirect and prediction pass through with one cycle of latency
        stim.rg_delayed_redirect = {1'b1, 64'h1234};
        stim.bpu_pred            = {$urandom_range(3, 0), $urandom, $urandom};
        step("redir");
        check("redir.val", 512'(p_rg_delayed_redirect), 512'({1'b1, 64'h1234}));

        // Mid-run reset with non-zero counters
        RST_N = 1'b0;
        stim.rg_pc           = 64'hdead_beef_0000_0010;
        stim.decoder_func_32 = '1;
        step("midrst");
        check("midrst.pc",  512'(p_rg_pc), 512'(64'hdead_beef_0000_0010));
        check("midrst.cnt", 512'({flush_cnt, pc_write_cnt, epoch_upd_cnt}), 512'(0));
        RST_N = 1'b1;

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            randomize_stim();
            RST_N = ($urandom_range(99, 0) < 4) ? 1'b0 : 1'b1;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
